// File: rtl/pipe_ctrl_if.sv
// Stall/flush controller bus: stage stall requests in, hold/flush controls out.
//   master: the pipeline side (drives requests, samples controls)
//   slave : pipe_ctrl (samples requests, drives controls)
interface pipe_ctrl_if;
    localparam int unsigned BBL_W = 6;
    localparam int unsigned SCNT_W = 32;

    logic              if_req_stall;
    logic              id_load_use;
    logic              ex_mdu_start;
    logic              ex_mdu_op;
    logic              mem_req_stall;
    logic              branch_flag_i;
    logic              excp_i;
    logic [BBL_W-1:0]  bbl_o;
    logic              branch_flush_o;
    logic              flush_o;
    logic              mdu_busy_o;
    logic              mdu_done_o;
    logic [SCNT_W-1:0] stall_cnt_o;

    modport master (
        output if_req_stall, id_load_use, ex_mdu_start, ex_mdu_op,
               mem_req_stall, branch_flag_i, excp_i,
        input  bbl_o, branch_flush_o, flush_o, mdu_busy_o, mdu_done_o,
               stall_cnt_o
    );

    modport slave (
        input  if_req_stall, id_load_use, ex_mdu_start, ex_mdu_op,
               mem_req_stall, branch_flag_i, excp_i,
        output bbl_o, branch_flush_o, flush_o, mdu_busy_o, mdu_done_o,
               stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller.
// Merges IF/ID/EX/MEM stall requests into the per-stage hold vector bbl_o
// ([0] PC .. [5] WB), sequences multi-cycle mult/div in EX, gates branch
// flushes, flushes the whole pipe on exceptions and counts stall cycles.
// Ports: clk, rst (sync, active-high), bus (pipe_ctrl_if.slave).
// Hold/flush/MDU status outputs are combinational (zero-cycle latency);
// stall_cnt_o is registered.
module pipe_ctrl #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned BBL_W  = 6;
    localparam int unsigned SCNT_W = 32;

    localparam logic [BBL_W-1:0] BBL_MEM  = 6'b011111;
    localparam logic [BBL_W-1:0] BBL_EX   = 6'b001111;
    localparam logic [BBL_W-1:0] BBL_ID   = 6'b000111;
    localparam logic [BBL_W-1:0] BBL_IF   = 6'b000011;
    localparam logic [BBL_W-1:0] BBL_NONE = 6'b000000;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SCNT_W-1:0] stall_cnt_q;

    logic              mdu_stall;
    logic [BBL_W-1:0]  bbl;
    logic              branch_flush;
    logic              flush;
    logic              mdu_busy;
    logic              mdu_done;

    // State, MDU counter and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (bbl != BBL_NONE && stall_cnt_q != {SCNT_W{1'b1}}) begin
                stall_cnt_q <= stall_cnt_q + SCNT_W'(1);
            end
        end
    end

    // MDU next state plus combinational hold/flush outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mdu_stall    = 1'b0;
        bbl          = BBL_NONE;
        branch_flush = 1'b0;
        flush        = 1'b0;
        mdu_busy     = 1'b0;
        mdu_done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A MEM stall freezes EX, so the op is not accepted yet.
                if (bus.ex_mdu_start && !bus.mem_req_stall) begin
                    mdu_stall = 1'b1;
                    if (!bus.excp_i) begin
                        state_d = BUSY;
                        cnt_d   = bus.ex_mdu_op ? DIV_LOAD : MULT_LOAD;
                    end
                end
            end
            BUSY: begin
                // The MDU keeps computing even while MEM holds EX.
                mdu_stall = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.mem_req_stall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Exception aborts any MDU op in flight.
        if (bus.excp_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        if (!rst) begin
            if (bus.excp_i) begin
                flush = 1'b1;
            end else if (bus.mem_req_stall) begin
                bbl = BBL_MEM;
            end else if (mdu_stall) begin
                bbl = BBL_EX;
            end else if (bus.id_load_use) begin
                bbl = BBL_ID;
            end else if (bus.if_req_stall) begin
                bbl = BBL_IF;
            end
            // A held ID stage re-presents the branch later.
            branch_flush = bus.branch_flag_i && !bbl[2] && !bus.excp_i;
            mdu_busy     = (state_q == BUSY);
            mdu_done     = (state_q == DONE);
        end
    end

    assign bus.bbl_o          = bbl;
    assign bus.branch_flush_o = branch_flush;
    assign bus.flush_o        = flush;
    assign bus.mdu_busy_o     = mdu_busy;
    assign bus.mdu_done_o     = mdu_done;
    assign bus.stall_cnt_o    = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random stimulus, all
// compared every cycle against a timeline-based reference model.
module tb_pipe_ctrl;
    localparam int unsigned MULT_N = 4;
    localparam int unsigned DIV_N  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Reference model: an accepted op occupies EX for n cycles from its start
    // cycle, then reports done until MEM lets it leave.
    bit     m_active = 1'b0;
    int     m_start  = 0;
    int     m_n      = 0;
    longint m_scnt   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic i_s, input logic lu, input logic st,
                        input logic op, input logic ms, input logic br, input logic ex);
        int         k;
        bit         busy_e, done_e, ex_st;
        logic [5:0] eb;
        @(negedge clk);
        rst               = r;
        bus.if_req_stall  = i_s;
        bus.id_load_use   = lu;
        bus.ex_mdu_start  = st;
        bus.ex_mdu_op     = op;
        bus.mem_req_stall = ms;
        bus.branch_flag_i = br;
        bus.excp_i        = ex;
        #1;
        k      = cyc - m_start;
        busy_e = m_active && k >= 1 && k <= m_n - 1;
        done_e = m_active && k >= m_n;
        ex_st  = (!m_active && st && !ms) || busy_e;
        if (r || ex)    eb = 6'b000000;
        else if (ms)    eb = 6'b011111;
        else if (ex_st) eb = 6'b001111;
        else if (lu)    eb = 6'b000111;
        else if (i_s)   eb = 6'b000011;
        else            eb = 6'b000000;
        chk("bbl",    32'(bus.bbl_o), 32'(eb));
        chk("flush",  32'(bus.flush_o), 32'(!r && ex));
        chk("bflush", 32'(bus.branch_flush_o), 32'(!r && br && !eb[2] && !ex));
        chk("busy",   32'(bus.mdu_busy_o), 32'(!r && busy_e));
        chk("done",   32'(bus.mdu_done_o), 32'(!r && done_e));
        chk("scnt",   bus.stall_cnt_o, 32'(m_scnt));
        @(posedge clk);
        if (r) begin
            m_active = 1'b0;
            m_scnt   = 0;
        end else begin
            if (eb != 6'b0 && m_scnt != 64'h0000_0000_FFFF_FFFF) m_scnt++;
            if (ex) begin
                m_active = 1'b0;
            end else if (!m_active && st && !ms) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_n      = op ? int'(DIV_N) : int'(MULT_N);
            end else if (done_e && !ms) begin
                m_active = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.if_req_stall  = 1'b0;
        bus.id_load_use   = 1'b0;
        bus.ex_mdu_start  = 1'b0;
        bus.ex_mdu_op     = 1'b0;
        bus.mem_req_stall = 1'b0;
        bus.branch_flag_i = 1'b0;
        bus.excp_i        = 1'b0;

        // Reset, including requests that must be masked while rst is high.
        step(1, 1, 1, 1, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_scnt", bus.stall_cnt_o, 32'd0);

        // Independent requests.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Seven stall cycles after reset.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, i[0], !i[0], 0, 0, 0, 0, 0);
        idle(1);
        chk("scnt7", bus.stall_cnt_o, 32'd7);

        // Mult: instruction held in EX until it leaves at end of cycle 5.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
        idle(2);

        // Div with a 2-cycle MEM stall mid-BUSY.
        for (int i = 0; i < 33; i++) step(0, 0, 0, 1, 1, (i == 10 || i == 11), 0, 0);
        idle(2);

        // Div with MEM stall held into DONE.
        for (int i = 0; i < 37; i++) step(0, 0, 0, 1, 1, (i >= 30 && i < 36), 0, 0);
        idle(2);

        // Exception during BUSY aborts the op.
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0, 0, (i == 5));
        idle(3);

        // Exception and start together: op not accepted.
        step(0, 0, 0, 1, 0, 0, 0, 1);
        idle(2);

        // Branch gating.
        step(0, 0, 1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 1, 0);

        // Reset mid-BUSY: no done pulse.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Stall counter saturation.
        #2;
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        m_scnt = 64'h0000_0000_FFFF_FFFD;
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("sat", bus.stall_cnt_o, 32'hFFFF_FFFF);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the five-stage pipeline. It merges stall requests from IF, ID, EX and MEM into the per-stage `bbl` vector that drives the PC register and every inter-stage register (if_id, id_ex, ex_mem, mem_wb). It also sequences multi-cycle mult/div operations in EX with an internal FSM and counter, gates branch flushes, performs the full-pipeline flush on exceptions, and counts stall cycles.

## Interface
Parameters:
- `MULT_CYCLES`, 4: EX stall cycles for a multiply (≥2)
- `DIV_CYCLES`, 32: EX stall cycles for a divide (≥2)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `if_req_stall`  in  1  instruction memory not ready
- `id_load_use`  in  1  load-use hazard detected in ID
- `ex_mdu_start`  in  1  EX holds a mult/div instruction
- `ex_mdu_op`  in  1  0 = mult, 1 = div (valid with `ex_mdu_start`)
- `mem_req_stall`  in  1  data memory wait
- `branch_flag_i`  in  1  taken branch resolved in ID
- `excp_i`  in  1  exception committed in MEM
- `bbl_o`  out  6  hold vector: [0] PC, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] WB
- `branch_flush_o`  out  1  clear if_id on the next edge
- `flush_o`  out  1  clear all pipeline registers and redirect the PC
- `mdu_busy_o`  out  1  MDU FSM in BUSY
- `mdu_done_o`  out  1  MDU result valid this cycle
- `stall_cnt_o`  out  32  saturating count of cycles with `bbl_o != 0`

## Operation
- Stall request priority: MEM > EX > ID > IF. The highest-priority active request alone sets `bbl_o`:
  - MEM: 6'b011111
  - EX (`mdu_stall`): 6'b001111
  - ID: 6'b000111
  - IF: 6'b000011
  - none: 6'b000000
- Each stage register holds when its bit is 1. A register whose bit is 1 and whose next bit is 0 inserts a bubble downstream.
- `mdu_stall` is combinational: (state==IDLE && ex_mdu_start && !mem_req_stall) || state==BUSY.
- MDU FSM states:
  - IDLE:
    - `ex_mdu_start` && !mem_req_stall && !excp_i: load `cnt` = (op ? DIV_CYCLES : MULT_CYCLES) − 1, go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY: `cnt` decrements every cycle, even when `mem_req_stall` is high. When `cnt`==1, go to DONE.
  - DONE: `mdu_done_o`=1 and no EX stall.
    - If `mem_req_stall`=1, stay in DONE (the EX instruction is held).
    - Otherwise go to IDLE.
  - `cnt` is 6 bits wide; parameters are limited to ≤63.
- Exception (`excp_i`=1):
  - `flush_o`=1 and `bbl_o`=0 combinationally. `excp_i` overrides all stall requests.
  - FSM is forced to IDLE and `cnt` to 0 on the next edge; any MDU operation in progress is aborted.
- `branch_flush_o` = branch_flag_i && !bbl_o[2] && !excp_i. A held ID stage re-presents the branch in a later cycle.
- `stall_cnt_o` increments on each edge where `bbl_o != 0` and saturates at 32'hFFFFFFFF.

## Timing
- Reset values: FSM in IDLE, `cnt`=0, `stall_cnt_o`=0. While `rst` is high, `bbl_o`=0, `branch_flush_o`=0, `flush_o`=0, `mdu_busy_o`=0, `mdu_done_o`=0 (outputs gated by `rst`).
- Stall, bubble, flush and branch-flush outputs are combinational from the inputs and the current state, with zero-cycle latency.
- MDU of N cycles, with no MEM stall:
  - EX is stalled for exactly N cycles: the start cycle plus N−1 BUSY cycles.
  - `mdu_done_o` is high in cycle N+1.
  - The instruction leaves EX at the end of cycle N+1.
- `ex_mdu_start` seen in BUSY or DONE is ignored; it is the same instruction.
- Reset mid-BUSY returns the FSM to IDLE on the next edge with no `mdu_done_o` pulse.
- `excp_i` and `ex_mdu_start` in the same cycle: the MDU operation is not accepted.

## Test plan
- Independent requests → `bbl_o`:
  - `if_req_stall` alone → 000011
  - `id_load_use` alone → 000111
  - `mem_req_stall` together with `id_load_use` → 011111
  - no requests → 000000
- Mult start (op=0, MULT_CYCLES=4) → `bbl_o`=001111 for 4 consecutive cycles, `mdu_busy_o` high for 3 of them, `mdu_done_o` high in cycle 5, then IDLE.
- Div start with `mem_req_stall` pulsed for 2 cycles mid-BUSY → `bbl_o`=011111 during the pulse, and done still arrives in cycle 33.
- Div start with `mem_req_stall` held high into DONE → FSM stays in DONE with `mdu_done_o` high until the stall drops, then returns to IDLE.
- `excp_i` asserted during BUSY → `flush_o`=1 and `bbl_o`=0 that cycle; next cycle IDLE, `mdu_busy_o`=0, no done pulse.
- `branch_flag_i` with `id_load_use` → `branch_flush_o`=0. `branch_flag_i` alone → `branch_flush_o`=1.
- `stall_cnt_o`: 7 stall cycles after reset → reads 7. Preloaded to saturation with a forced stall → stays at FFFFFFFF.
